// File: rtl/sobel_edge_filter.sv
// Streaming 3x3 Sobel edge detector for 12-bit grey pixels: two line buffers, 3-stage pipeline.
// Optional build macro SOBEL_BINARY_EN thresholds modes 01/10/11 against THRESH.
module sobel_edge_filter #(
  parameter int          WIDTH  = 640,
  parameter logic [11:0] THRESH = 12'd256
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSOF,
  input  logic [11:0] iDATA,
  input  logic        iDVAL,
  input  logic [1:0]  iMODE,
  output logic [11:0] oDATA,
  output logic        oDVAL
);

  localparam logic [9:0] LAST_COL = 10'(WIDTH - 1);

  logic [9:0]  col_r, col_s;
  logic [1:0]  row_r, row_s;
  logic [11:0] lb0_r [0:WIDTH-1];
  logic [11:0] lb1_r [0:WIDTH-1];
  logic [11:0] lb0_rd_s, lb1_rd_s;
  logic        inner_s;
  logic [11:0] a11_r, a12_r, a13_r, a21_r, a22_r, a23_r, a31_r, a32_r, a33_r;
  logic        vld0_r, inner0_r;
  logic [15:0] gx_pos_s, gx_neg_s, gy_pos_s, gy_neg_s;
  logic signed [15:0] gx1_r, gy1_r;
  logic [11:0] cen1_r;
  logic        vld1_r, inner1_r;
  logic [14:0] abs_gx_s, abs_gy_s, sel_s;
  logic [11:0] sat_s, res_s, out_s;

  function automatic logic [14:0] abs15(input logic signed [15:0] v);
    logic [15:0] neg;
    neg = 16'd0 - 16'(v);
    return v[15] ? neg[14:0] : 15'(v);
  endfunction

  // Effective position of the accepted pixel; iSOF forces it to (0,0) and reads are pre-write.
  always_comb begin
    col_s = col_r;
    row_s = row_r;
    if (iSOF) begin
      col_s = 10'd0;
      row_s = 2'd0;
    end else begin
      col_s = col_r;
      row_s = row_r;
    end
    lb0_rd_s = lb0_r[col_s];
    lb1_rd_s = lb1_r[col_s];
    inner_s  = (row_s == 2'd2) && (col_s >= 10'd2);
  end

  // Column/row counters; row saturates at 2
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      col_r <= 10'd0;
      row_r <= 2'd0;
    end else if (iDVAL) begin
      if (col_s == LAST_COL) begin
        col_r <= 10'd0;
        row_r <= (row_s == 2'd2) ? 2'd2 : row_s + 2'd1;
      end else begin
        col_r <= col_s + 10'd1;
        row_r <= row_s;
      end
    end else if (iSOF) begin
      col_r <= 10'd0;
      row_r <= 2'd0;
    end else begin
      col_r <= col_r;
      row_r <= row_r;
    end
  end

  // Line buffers, deliberately not reset
  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      lb0_r[col_s] <= iDATA;
      lb1_r[col_s] <= lb0_rd_s;
    end
  end

  // Stage 0: window shift and border flag
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      {a11_r, a12_r, a13_r} <= {12'd0, 12'd0, 12'd0};
      {a21_r, a22_r, a23_r} <= {12'd0, 12'd0, 12'd0};
      {a31_r, a32_r, a33_r} <= {12'd0, 12'd0, 12'd0};
      vld0_r   <= 1'b0;
      inner0_r <= 1'b0;
    end else begin
      vld0_r <= iDVAL;
      if (iDVAL) begin
        {a11_r, a12_r, a13_r} <= {a12_r, a13_r, lb1_rd_s};
        {a21_r, a22_r, a23_r} <= {a22_r, a23_r, lb0_rd_s};
        {a31_r, a32_r, a33_r} <= {a32_r, a33_r, iDATA};
        inner0_r <= inner_s;
      end else begin
        inner0_r <= inner0_r;
      end
    end
  end

  // Gradient partial sums, non-negative so plain unsigned adds suffice
  always_comb begin
    gx_pos_s = {4'd0, a13_r} + {3'd0, a23_r, 1'b0} + {4'd0, a33_r};
    gx_neg_s = {4'd0, a11_r} + {3'd0, a21_r, 1'b0} + {4'd0, a31_r};
    gy_pos_s = {4'd0, a31_r} + {3'd0, a32_r, 1'b0} + {4'd0, a33_r};
    gy_neg_s = {4'd0, a11_r} + {3'd0, a12_r, 1'b0} + {4'd0, a13_r};
  end

  // Stage 1: register gradients and side-band
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      gx1_r    <= 16'sd0;
      gy1_r    <= 16'sd0;
      cen1_r   <= 12'd0;
      vld1_r   <= 1'b0;
      inner1_r <= 1'b0;
    end else begin
      gx1_r    <= signed'(gx_pos_s - gx_neg_s);
      gy1_r    <= signed'(gy_pos_s - gy_neg_s);
      cen1_r   <= a22_r;
      vld1_r   <= vld0_r;
      inner1_r <= inner0_r;
    end
  end

  // Stage 2 combinational: magnitude select, saturation, border zeroing
  always_comb begin
    abs_gx_s = abs15(gx1_r);
    abs_gy_s = abs15(gy1_r);
    case (iMODE)
      2'b01:   sel_s = abs_gx_s;
      2'b10:   sel_s = abs_gy_s;
      2'b11:   sel_s = abs_gx_s + abs_gy_s;
      default: sel_s = 15'd0;
    endcase
    sat_s = (sel_s > 15'd4095) ? 12'hFFF : sel_s[11:0];
`ifdef SOBEL_BINARY_EN
    res_s = (sat_s >= THRESH) ? 12'hFFF : 12'd0;
`else
    res_s = sat_s;
`endif
    if (!inner1_r) begin
      out_s = 12'd0;
    end else if (iMODE == 2'b00) begin
      out_s = cen1_r;
    end else begin
      out_s = res_s;
    end
  end

`ifndef SOBEL_BINARY_EN
  logic unused_thresh_s;
  assign unused_thresh_s = ^THRESH;
`endif

  // Stage 2 register: output holds while no valid pixel
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDATA <= 12'd0;
      oDVAL <= 1'b0;
    end else begin
      oDVAL <= vld1_r;
      if (vld1_r) begin
        oDATA <= out_s;
      end else begin
        oDATA <= oDATA;
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Randomised bench for sobel_edge_filter against a frame-array reference model.
module tb_sobel_edge_filter;
  localparam int W   = 640;
  localparam int THR = 256;

  logic        D5M_PIXLCLK = 1'b0;
  logic        iRST, iSOF, iDVAL;
  logic [11:0] iDATA;
  logic [1:0]  iMODE;
  logic [11:0] oDATA;
  logic        oDVAL;

  sobel_edge_filter #(.WIDTH(W), .THRESH(12'(THR))) dut (
    .iCLK(D5M_PIXLCLK), .iRST(iRST), .iSOF(iSOF), .iDATA(iDATA),
    .iDVAL(iDVAL), .iMODE(iMODE), .oDATA(oDATA), .oDVAL(oDVAL)
  );

  always #5 D5M_PIXLCLK = ~D5M_PIXLCLK;

  typedef struct {
    bit inner;
    int center;
    int gx;
    int gy;
  } exp_t;

  int   total_cnt = 0;
  int   bad_cnt   = 0;
  int   pulse_cnt = 0;
  int   mode_cfg  = 3;
  int   img [4][W];
  int   px_x = 0, px_y = 0;
  int   mode_last = 0;
  int   last_out = 0;
  logic [2:0] hist = 3'b000;
  exp_t exp_q [$];

  task automatic check_val(input string tag, input int obs, input int expv);
    total_cnt++;
    if (obs != expv) begin
      bad_cnt++;
      if (bad_cnt <= 20) $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int pv(int row, int col);
    return img[row % 4][col];
  endfunction

  // Sobel result for the window ending at (y,x), straight from the kernel definitions
  function automatic exp_t model_px(int y, int x);
    exp_t e;
    int wgt [3] = '{1, 2, 1};
    e.inner = (y >= 2) && (x >= 2);
    e.center = 0; e.gx = 0; e.gy = 0;
    if (e.inner) begin
      e.center = pv(y - 1, x - 1);
      for (int k = 0; k < 3; k++) begin
        e.gx += wgt[k] * (pv(y - 2 + k, x) - pv(y - 2 + k, x - 2));
        e.gy += wgt[k] * (pv(y, x - 2 + k) - pv(y - 2, x - 2 + k));
      end
    end
    return e;
  endfunction

  function automatic int final_val(exp_t e, int mode);
    int m;
    if (!e.inner) return 0;
    if (mode == 0) return e.center;
    case (mode)
      1:       m = (e.gx < 0 ? -e.gx : e.gx);
      2:       m = (e.gy < 0 ? -e.gy : e.gy);
      default: m = (e.gx < 0 ? -e.gx : e.gx) + (e.gy < 0 ? -e.gy : e.gy);
    endcase
    if (m > 4095) m = 4095;
`ifdef SOBEL_BINARY_EN
    return (m >= THR) ? 4095 : 0;
`else
    return m;
`endif
  endfunction

  // Reference model: record accepted pixels and queue their expected results
  always @(posedge D5M_PIXLCLK) begin
    mode_last = int'(iMODE);
    if (iRST) begin
      px_x = 0; px_y = 0; hist = 3'b000;
      exp_q.delete();
    end else begin
      hist = {hist[1:0], iDVAL};
      if (iSOF) begin px_x = 0; px_y = 0; end
      if (iDVAL) begin
        img[px_y % 4][px_x] = int'(iDATA);
        exp_q.push_back(model_px(px_y, px_x));
        px_x++;
        if (px_x == W) begin px_x = 0; px_y++; end
      end
    end
  end

  // Output checker, sampled away from the active edge
  always @(negedge D5M_PIXLCLK) begin
    exp_t e;
    if (iRST) begin
      check_val("rst_dval", int'(oDVAL), 0);
      check_val("rst_data", int'(oDATA), 0);
      last_out = 0;
    end else begin
      check_val("dval_delay", int'(oDVAL), int'(hist[2]));
      if (oDVAL) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          check_val("q_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("data", int'(oDATA), final_val(e, mode_last));
        end
      end else begin
        check_val("hold", int'(oDATA), last_out);
      end
      last_out = int'(oDATA);
    end
  end

  function automatic int pix(int kind, int row, int col);
    case (kind)
      0:       return 100;
      1:       return (col < 320) ? 0 : 1000;
      2:       return (row < 2) ? 0 : 4095;
      3:       return (col * 10) % 4096;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic send(input int d, input bit v, input bit s);
    iDATA = 12'(d);
    iDVAL = v;
    iSOF  = s;
    iMODE = (mode_cfg > 3) ? 2'($urandom_range(0, 3)) : 2'(mode_cfg);
    @(posedge D5M_PIXLCLK);
    #1;
  endtask

  // gap: 0 continuous, 1 every other cycle, 2 random idle cycles
  task automatic send_frame(input int kind, input int nrows, input int last_cols,
                            input int gap, input bit sof_first);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < ((r == nrows - 1) ? last_cols : W); c++) begin
        if (gap == 1) send(int'($urandom_range(0, 4095)), 1'b0, 1'b0);
        if (gap == 2) repeat ($urandom_range(0, 2)) send(0, 1'b0, 1'b0);
        send(pix(kind, r, c), 1'b1, sof_first && r == 0 && c == 0);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) send(0, 1'b0, 1'b0);
  endtask

  initial begin
    iRST = 1'b1; iSOF = 1'b0; iDVAL = 1'b0; iDATA = 12'd0; iMODE = 2'd0;
    repeat (3) @(posedge D5M_PIXLCLK);
    #1 iRST = 1'b0;

    // Reset mid-stream, then flat field
    mode_cfg = 4;
    send_frame(4, 1, 200, 0, 1'b0);
    iRST = 1'b1;
    idle(3);
    iRST = 1'b0;
    pulse_cnt = 0;
    mode_cfg = 3;
    send_frame(0, 3, W, 0, 1'b0);
    idle(5);
    check_val("flat_pulses", pulse_cnt, 3 * W);

    // Vertical edge in each gradient mode, then random mode per cycle
    mode_cfg = 1; send_frame(1, 4, W, 0, 1'b1);
    mode_cfg = 2; send_frame(1, 4, W, 0, 1'b1);
    mode_cfg = 4; send_frame(1, 4, W, 0, 1'b1);

    // Saturating horizontal edge, magnitude and centre modes
    mode_cfg = 3; send_frame(2, 4, W, 0, 1'b1);
    mode_cfg = 0; send_frame(2, 4, W, 0, 1'b1);

    // Gapped vertical edge with a frame restart 100 pixels into row 3
    mode_cfg = 1; send_frame(1, 4, 100, 1, 1'b1);
    send_frame(1, 3, W, 1, 1'b1);

    // Ramp, then random pixels with random gaps and modes after an idle iSOF
    mode_cfg = 1; send_frame(3, 3, W, 0, 1'b1);
    send(0, 1'b0, 1'b1);
    mode_cfg = 4; send_frame(4, 4, W, 2, 1'b0);

    idle(6);
    check_val("leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule

// File: doc/sobel_edge_filter.md
# sobel_edge_filter

Streaming 3x3 Sobel edge detector for the 12-bit grey pixel stream. It sits directly downstream of the raw-to-grey converter and upstream of the frame-buffer write mux. It consumes `iDATA`/`iDVAL` at pixel-clock rate and emits one 12-bit edge-magnitude pixel per accepted input pixel. Two internal line buffers feed a sliding 3x3 window.

## Interface
Parameters:
- `WIDTH`, 640: pixels per line; column counter wraps here.
- `THRESH`, 12'd256: binarisation threshold, used only with `SOBEL_BINARY_EN`.

Ports:
- `iCLK`, in, 1: pixel clock. This is the block's only clock.
- `iRST`, in, 1: reset, asynchronous, active-high.
- `iSOF`, in, 1: start-of-frame pulse. Forces column and row counters to 0.
- `iDATA`, in, 12: grey pixel.
- `iDVAL`, in, 1: `iDATA` valid. Gaps are allowed.
- `iMODE`, in, 2: output select. 00 = centre pixel, 01 = |Gx|, 10 = |Gy|, 11 = |Gx|+|Gy|.
- `oDATA`, out, 12: filtered pixel.
- `oDVAL`, out, 1: `oDATA` valid.

## Operation
**Counters**
- Column `c` (10b): increments on each `iDVAL`. At `c==WIDTH-1` it wraps to 0 and advances row `r`.
- Row `r` (2b): saturates at 2.
- `iSOF` sets `c=0`, `r=0`. If `iDVAL` is high in the same cycle, that pixel is (0,0) and counters end at `c=1`, `r=0`.

**Line buffers**
- LB0 holds the previous row; LB1 holds the row before that. Each is `WIDTH`x12.
- On `iDVAL`: read LB0[c] and LB1[c]; write LB0[c]<=`iDATA` and LB1[c]<=old LB0[c]. Read-during-write returns old data.
- Line buffer contents are not reset.

**Window**
- Registers a11..a33. On `iDVAL` they shift left one column.
- The new right column is {LB1[c], LB0[c], `iDATA`}, top to bottom.
- The window centre is the pixel at (r-1, c-1).

**Arithmetic**
- Gx = (a13+2a23+a33) - (a11+2a21+a31), 16b signed.
- Gy = (a31+2a32+a33) - (a11+2a12+a13), 16b signed.
- Magnitude = |Gx|+|Gy|, 15b unsigned.
- The selected result saturates to 12'hFFF.
- Mode 00 outputs a22 unmodified.

**Border**
- Stage-0 valid flag `inner` = (r>=2 && c>=2), evaluated for the accepted pixel.
- If `inner`==0, `oDATA`=0 in all modes.
- Net effect: the output image is offset by one row and one column, with the top 2 rows and left 2 columns zero.

**Mode input**
- `iMODE` is sampled in stage 2 every cycle. A change takes effect on the next output, including mid-frame.

**Reset**
- Counters, window, pipeline registers, `oDATA` and `oDVAL` all reset to 0.
- Reset mid-frame behaves as a fresh frame start.

## Timing
- Pipeline has 3 stages. It never stalls and advances every clock.
  - S0: window/counter update on `iDVAL`.
  - S1: Gx/Gy registered.
  - S2: abs/sum/saturate registered to `oDATA`.
- `iDVAL` high in cycle n gives `oDVAL` high in cycle n+3.
- The `oDVAL` pattern equals `iDVAL` delayed by exactly 3 cycles. Gaps are preserved.
- `oDATA` holds its last value while `oDVAL`=0.
- Output count equals input count.
- No backpressure and no ready signal.

## Configuration
- Macro: `SOBEL_BINARY_EN`.
- Defined: in modes 01/10/11 the saturated result is compared `>= THRESH`. The output is 12'hFFF on pass, 0 otherwise. Mode 00 and border zeroing are unchanged.
- Undefined: the saturated magnitude is output directly. `THRESH` is unused.

## Test plan
1. **Reset and flat field.** Assert `iRST` mid-stream; then drive constant 100 on 3 lines, mode 11.
   - `oDATA`=0 and `oDVAL`=0 during reset.
   - All outputs are 0.
   - Exactly 1920 `oDVAL` pulses, each 3 cycles after its `iDVAL`.
2. **Vertical edge.** Columns <320 = 0, >=320 = 1000, 4 lines.
   - Mode 01, rows 2..3: `oDATA`=4000 at input c=320 and c=321, 0 elsewhere.
   - Mode 10: all 0.
3. **Saturation and horizontal edge.** Rows 0..1 = 0, rows 2+ = 4095, mode 11.
   - Input row 2 and row 3, c>=2: `oDATA`=4095 (|Gy|=16380, saturated). All other rows 0.
   - Mode 00: input row 3 outputs 4095 (centre = row 2).
4. **Gapped input and `iSOF`.**
   - Drive the same image as case 2, with `iDVAL` every other cycle. Output values must be identical to continuous drive; `oDVAL` alternates, delayed 3.
   - Pulse `iSOF` after 100 pixels of row 3. The next 2 rows plus columns 0..1 output 0. Counters restart with c=0.
5. **`SOBEL_BINARY_EN` build, `THRESH`=256.**
   - Case-2 edge gives 4095 at c=320/321.
   - A horizontal ramp of +10 per pixel (|Gx|=80) gives 0.
   - Mode 00 still passes the centre pixel.
